// File: rtl/irq_timer.sv
// irq_timer: memory-mapped countdown timer driving a level interrupt request.
// Ports: clk/reset (sync, active-high); addr/we/din/dout word-register bus
//        (0=CTRL, 1=PRESET, 2=COUNT, 3=unused); irq registered level output.
// Latency: reads are combinational; writes are visible the cycle after the we edge.
module irq_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_RELOAD = 2'b01;

    state_t      state;
    logic [3:0]  ctrl;       // [3] IM, [2:1] mode, [0] enable
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;

    logic        enable;
    logic [1:0]  mode;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [3:0]  ctrl_nxt;
    logic        flag_nxt;

    assign enable    = ctrl[0];
    assign mode      = ctrl[2:1];
    assign wr_ctrl   = we && (addr == 2'd0);
    assign wr_preset = we && (addr == 2'd1);

    // Next CTRL and flag values. Software writes are applied last so they
    // override the FSM's own updates in the same cycle.
    always_comb begin
        ctrl_nxt = ctrl;
        flag_nxt = irq_flag;
        if (state == ST_CNT && enable && count <= 32'd1) begin
            flag_nxt = 1'b1;
        end
        if (state == ST_INT) begin
            if (mode == MODE_RELOAD) begin
                flag_nxt = 1'b0;
            end else begin
                ctrl_nxt[0] = 1'b0;
            end
        end
        if (wr_ctrl) begin
            ctrl_nxt = din[3:0];
            flag_nxt = 1'b0;
        end
        if (wr_preset) begin
            flag_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            ctrl     <= ctrl_nxt;
            irq_flag <= flag_nxt;
            // Registered output built from next-state values so irq tracks
            // the flag and mask on the same edge that updates them.
            irq      <= flag_nxt & ctrl_nxt[3];
            if (wr_preset) begin
                preset <= din;
            end
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        // Covers count 0 too, so PRESET=0 acts like 1 and the
                        // counter can never wrap.
                        count <= 32'd0;
                        state <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (mode == MODE_RELOAD) begin
                        state <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        case (addr)
            2'd0:    dout = {28'd0, ctrl};
            2'd1:    dout = preset;
            2'd2:    dout = count;
            default: dout = 32'd0;
        endcase
    end

endmodule

// File: doc/irq_timer.md
# irq_timer

Memory-mapped countdown timer that raises a hardware interrupt request toward the coprocessor-0 interrupt logic. Software programs it through three word registers on the bridge, and its `irq` output drives `HWInt[10]`. It is the interrupt source at the far end of the CP0 `HWInt` path. Software acknowledges an interrupt by rewriting CTRL or PRESET.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  2  word select (byte address bits [3:2]): 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = unused.
- `we`  in  1  write enable for the word selected by `addr`.
- `din`  in  32  write data.
- `dout`  out  32  read data, combinational from `addr`.
- `irq`  out  1  interrupt request, level, registered; connects to CP0 `HWInt[10]`.

## Operation
- Registers:
  - CTRL[3:0]: bit 3 IM (interrupt mask), bits [2:1] Mode, bit 0 Enable. CTRL[31:4] read as 0.
  - PRESET[31:0]: reload value.
  - COUNT[31:0]: read-only to software.
- Reads: `dout` = {28'b0, CTRL} / PRESET / COUNT / 0 for `addr` 0 / 1 / 2 / 3.
- Writes with `we`=1:
  - `addr` 0: CTRL <= din[3:0] and clear irq_flag.
  - `addr` 1: PRESET <= din and clear irq_flag.
  - `addr` 2 and `addr` 3: ignored.
- `irq` = irq_flag & IM.
- FSM states are IDLE, LOAD, CNT, INT. Each transition takes one edge.
  - IDLE: if Enable, go to LOAD. Otherwise stay; COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If !Enable, go to IDLE; COUNT holds.
    - Else if COUNT > 1, COUNT <= COUNT - 1.
    - Else (COUNT is 0 or 1): COUNT <= 0, irq_flag <= 1, go to INT.
  - INT, Mode 01 (auto-reload): irq_flag <= 0; go to LOAD.
  - INT, Mode 00, 10 or 11 (one-shot): Enable <= 0; go to IDLE. irq_flag stays set until a CTRL or PRESET write.
- Arithmetic: COUNT decrement is 32-bit unsigned. It never wraps, because the 0/1 case always terminates to INT. PRESET=0 behaves like PRESET=1.
- Simultaneous events:
  - A software CTRL write in the same cycle as the INT one-shot Enable clear: the software value wins.
  - A CTRL/PRESET write clears irq_flag even in the same cycle the FSM would set it; the clear wins.
  - The state transition proceeds regardless of the write.
- A PRESET write during CNT does not disturb COUNT. It takes effect at the next LOAD.
- Disabling mid-count (Enable=0 in CNT) returns to IDLE with COUNT frozen. Re-enabling reloads from PRESET and does not resume.
- Reset mid-operation: on the reset edge, all state returns to reset values regardless of FSM state or a pending write.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0, `irq`=0.
- Register writes become visible on `dout` the cycle after the `we` edge. Reads have zero latency.
- Count sequence, with edge E0 taken as the one that writes Enable=1 (PRESET=N≥1, state IDLE):
  - E1 enters LOAD.
  - E2 enters CNT with COUNT=N.
  - E(2+k) gives COUNT=N−k.
  - E(N+2) enters INT with `irq`=1 (if IM=1).
- Mode 01: `irq` is high for exactly one cycle per period. Period = N+2 cycles (INT, LOAD, then N cycles in CNT).
- Mode 00: `irq` rises at E(N+2) and stays high until the edge of a CTRL/PRESET write. Enable reads 0 from E(N+3).
- IM only gates the output. irq_flag is set and cleared identically whether IM is 0 or 1. Setting IM=1 later through a CTRL write clears the flag, so no stale interrupt is delivered.

## Test plan
- Reset is held, then released with no writes → `dout` reads 0 at all four addresses, `irq`=0, COUNT stays 0 for 20 cycles.
- Write PRESET=5, then CTRL=4'b1001 (IM, mode 0, Enable) → COUNT reads 5,4,3,2,1,0. `irq` rises exactly 7 edges after the CTRL write and stays high. CTRL reads 4'b1000. Writing CTRL=0 drops `irq` on the next edge.
- PRESET=3, CTRL=4'b1011 (mode 1) → `irq` is a single-cycle pulse every 5 cycles for at least 4 periods; COUNT reloads to 3 each period.
- Mode 1 running with PRESET=10 and COUNT=6: write CTRL=4'b1010 (Enable=0) → COUNT freezes at its value after the write edge and `irq` never asserts. Rewriting Enable=1 → COUNT restarts from 10.
- Mode 0 with IM=0 and PRESET=2 → `irq` stays 0 and the FSM returns to IDLE. PRESET=0 with IM=1 → `irq` rises 3 edges after the enable write.
- Assert `reset` for one cycle while in CNT with COUNT=7 → next cycle CTRL, PRESET and COUNT read 0, and `irq`=0.
